// File: rtl/qsfp_test_pkg.sv
// qsfp_test_pkg
// Shared definitions for the QSFP bandwidth generator and receive checker:
// window size, stream widths, the common test-state encoding and a
// 64-to-16-bit saturation helper.
package qsfp_test_pkg;

    localparam logic [31:0] ONE_GB  = 32'h0200_0000;  // 256-bit beats in 1 GB
    localparam int          AXIS_DW = 256;
    localparam int          STAMP_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } test_state_t;

    // Clamp a 64-bit cycle distance into a 16-bit gap register.
    function automatic logic [15:0] sat16(input logic [63:0] value);
        if (value[63:16] != 48'd0) begin
            return 16'hFFFF;
        end
        return value[15:0];
    endfunction

endpackage

// File: rtl/sat_inc.sv
// sat_inc
// Combinational saturating update for a W-bit counter/statistic.
//   cur  : current register value
//   cand : candidate value, used only when inc=0
//   inc  : 1 -> nxt = cur+1, held at all-ones once reached
//          0 -> nxt = max(cur, cand) (unsigned)
//   nxt  : next register value
module sat_inc #(
    parameter int W = 32
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] cand,
    input  logic         inc,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != {W{1'b1}}) begin
                nxt = cur + W'(1);
            end
        end else if (cand > cur) begin
            nxt = cand;
        end
    end

endmodule

// File: rtl/qsfp_rx_checker.sv
// qsfp_rx_checker
// Receive-side verifier for the QSFP bandwidth test. Checks that each beat
// carries a strictly increasing 64-bit stamp in TDATA[63:0], zero upper bits
// and TLAST, and measures a BEAT_COUNT-beat window.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle pulse, arms a window from IDLE or DONE
//   stall_mask[7:0]       TREADY pattern indexed by cyc[2:0] while measuring
//   busy, done            ARMED/MEASURE and DONE indications
//   beats_rcvd            beats accepted in this window
//   error_count           failed beats (saturating)
//   first_error_beat      1-based index of first failing beat, 0 if none
//   last_value            stamp of the most recent accepted beat
//   rx_time               cycles from first to last accepted beat
//   max_gap               largest distance between accepts (saturating)
//   IN_AXIS_*             256-bit AXI stream sink, registered TREADY
//   state_dbg             current FSM state
//
// Handshake: a beat transfers on a rising edge where IN_AXIS_TVALID and the
// registered IN_AXIS_TREADY are both high; TREADY never depends
// combinationally on TVALID.
module qsfp_rx_checker
    import qsfp_test_pkg::*;
#(
    parameter logic [31:0] BEAT_COUNT = ONE_GB
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         stall_mask,
    output logic               busy,
    output logic               done,
    output logic [31:0]        beats_rcvd,
    output logic [31:0]        error_count,
    output logic [31:0]        first_error_beat,
    output logic [STAMP_W-1:0] last_value,
    output logic [63:0]        rx_time,
    output logic [15:0]        max_gap,
    input  logic [AXIS_DW-1:0] IN_AXIS_TDATA,
    input  logic               IN_AXIS_TVALID,
    input  logic               IN_AXIS_TLAST,
    output logic               IN_AXIS_TREADY,
    output test_state_t        state_dbg
);

    test_state_t        state;
    test_state_t        state_next;
    logic [63:0]        cyc;
    logic [63:0]        t0;
    logic [63:0]        prev_cyc;
    logic               accept;
    logic               fail_shape;
    logic               fail_order;
    logic [31:0]        beats_next;
    logic [31:0]        err_next;
    logic [15:0]        gap_next;

    assign accept     = IN_AXIS_TREADY & IN_AXIS_TVALID;
    // Upper-zero and TLAST apply to every beat; ordering only after the first.
    assign fail_shape = (IN_AXIS_TDATA[AXIS_DW-1:STAMP_W] != '0) | ~IN_AXIS_TLAST;
    assign fail_order = IN_AXIS_TDATA[STAMP_W-1:0] <= last_value;
    assign beats_next = beats_rcvd + 32'd1;
    assign state_dbg  = state;

    sat_inc #(.W(32)) u_err_inc (
        .cur  (error_count),
        .cand (32'd0),
        .inc  (1'b1),
        .nxt  (err_next)
    );

    sat_inc #(.W(16)) u_gap_max (
        .cur  (max_gap),
        .cand (sat16(cyc - prev_cyc)),
        .inc  (1'b0),
        .nxt  (gap_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = ARMED;
            ARMED:      if (accept) state_next = (BEAT_COUNT == 32'd1) ? DONE : MEASURE;
            MEASURE:    if (accept && beats_next == BEAT_COUNT) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            cyc              <= 64'd0;
            t0               <= 64'd0;
            prev_cyc         <= 64'd0;
            IN_AXIS_TREADY   <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            beats_rcvd       <= 32'd0;
            error_count      <= 32'd0;
            first_error_beat <= 32'd0;
            last_value       <= '0;
            rx_time          <= 64'd0;
            max_gap          <= 16'd0;
        end else begin
            state <= state_next;
            cyc   <= cyc + 64'd1;
            // Ready is decided from the state being entered, so DONE drains
            // from its first cycle and the mask lags cyc by one cycle.
            if (state_next == ARMED || state_next == MEASURE) begin
                IN_AXIS_TREADY <= ~stall_mask[cyc[2:0]];
            end else begin
                IN_AXIS_TREADY <= 1'b1;
            end
            busy <= (state_next == ARMED) || (state_next == MEASURE);
            done <= (state_next == DONE);

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        beats_rcvd       <= 32'd0;
                        error_count      <= 32'd0;
                        first_error_beat <= 32'd0;
                        max_gap          <= 16'd0;
                        rx_time          <= 64'd0;
                    end
                end
                ARMED: begin
                    if (accept) begin
                        beats_rcvd <= 32'd1;
                        last_value <= IN_AXIS_TDATA[STAMP_W-1:0];
                        t0         <= cyc;
                        prev_cyc   <= cyc;
                        rx_time    <= 64'd0;
                        if (fail_shape) begin
                            error_count      <= err_next;
                            first_error_beat <= 32'd1;
                        end
                    end
                end
                MEASURE: begin
                    if (accept) begin
                        beats_rcvd <= beats_next;
                        last_value <= IN_AXIS_TDATA[STAMP_W-1:0];
                        prev_cyc   <= cyc;
                        max_gap    <= gap_next;
                        if (fail_shape || fail_order) begin
                            error_count <= err_next;
                            if (first_error_beat == 32'd0) begin
                                first_error_beat <= beats_next;
                            end
                        end
                        if (beats_next == BEAT_COUNT) begin
                            rx_time <= cyc - t0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qsfp_rx_checker.sv
// Bench for qsfp_rx_checker. Six checkers with BEAT_COUNT 1,2,3,4,5,8 share
// one stimulus stream; each scenario targets one instance.
module tb_qsfp_rx_checker;
    import qsfp_test_pkg::*;

    localparam int NDUT = 6;
    localparam logic [31:0] BC_TAB [NDUT] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd8};

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   stall_mask = 8'd0;
    logic [255:0] tdata = '0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;

    logic         busy_v  [NDUT];
    logic         done_v  [NDUT];
    logic         tready_v[NDUT];
    logic [31:0]  beats_v [NDUT];
    logic [31:0]  err_v   [NDUT];
    logic [31:0]  ferr_v  [NDUT];
    logic [63:0]  last_v  [NDUT];
    logic [63:0]  rx_v    [NDUT];
    logic [15:0]  gap_v   [NDUT];
    test_state_t  st_v    [NDUT];

    int checks = 0;
    int errors = 0;
    logic [63:0] tb_cyc = 64'd0;   // reference cycle counter

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) tb_cyc <= 64'd0;
        else       tb_cyc <= tb_cyc + 64'd1;
    end

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        qsfp_rx_checker #(.BEAT_COUNT(BC_TAB[g])) u_dut (
            .clock            (clock),
            .reset            (reset),
            .start            (start),
            .stall_mask       (stall_mask),
            .busy             (busy_v[g]),
            .done             (done_v[g]),
            .beats_rcvd       (beats_v[g]),
            .error_count      (err_v[g]),
            .first_error_beat (ferr_v[g]),
            .last_value       (last_v[g]),
            .rx_time          (rx_v[g]),
            .max_gap          (gap_v[g]),
            .IN_AXIS_TDATA    (tdata),
            .IN_AXIS_TVALID   (tvalid),
            .IN_AXIS_TLAST    (tlast),
            .IN_AXIS_TREADY   (tready_v[g]),
            .state_dbg        (st_v[g])
        );
    end

    typedef struct {
        int                idx;
        int                n;
        logic [7:0][63:0]  stamp;
        logic [7:0]        upper;
        logic [7:0]        last;
        logic [7:0]        mask;
        logic              start_last;
        logic [31:0]       e_beats;
        logic [31:0]       e_err;
        logic [31:0]       e_first;
        logic [63:0]       e_last;
        logic [63:0]       e_rx;
        logic [15:0]       e_gap;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(int idx, int n,
                                logic [63:0] s0, logic [63:0] s1, logic [63:0] s2, logic [63:0] s3,
                                logic [63:0] s4, logic [63:0] s5, logic [63:0] s6, logic [63:0] s7,
                                logic [7:0] up, logic [7:0] lst, logic [7:0] mask, logic sl,
                                logic [31:0] eb, logic [31:0] ee, logic [31:0] ef,
                                logic [63:0] el, logic [63:0] er, logic [15:0] eg);
        vec_t v;
        v.idx = idx; v.n = n;
        v.stamp[0] = s0; v.stamp[1] = s1; v.stamp[2] = s2; v.stamp[3] = s3;
        v.stamp[4] = s4; v.stamp[5] = s5; v.stamp[6] = s6; v.stamp[7] = s7;
        v.upper = up; v.last = lst; v.mask = mask; v.start_last = sl;
        v.e_beats = eb; v.e_err = ee; v.e_first = ef;
        v.e_last = el; v.e_rx = er; v.e_gap = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tvalid = 1'b0; start = 1'b0; tlast = 1'b0; stall_mask = 8'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Holds TVALID until the target instance accepts the current beat.
    // Called and returns on a falling edge.
    task automatic offer(input int idx);
        int   waited = 0;
        logic r;
        tvalid = 1'b1;
        do begin
            r = tready_v[idx];
            @(negedge clock);
            waited++;
        end while (!r && waited < 100);
        if (!r) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int num);
        string tag;
        tag = $sformatf("vec%0d", num);
        do_reset();
        stall_mask = v.mask;
        pulse_start();
        for (int i = 0; i < v.n; i++) begin
            tdata = {(v.upper[i] ? 192'd1 : 192'd0), v.stamp[i]};
            tlast = v.last[i];
            start = v.start_last && (i == v.n - 1);
            offer(v.idx);
        end
        tvalid = 1'b0; start = 1'b0; tlast = 1'b0;
        chk({tag, "_done"},        done_v[v.idx], 1);
        chk({tag, "_busy"},        busy_v[v.idx], 0);
        chk({tag, "_beats"},       beats_v[v.idx], v.e_beats);
        chk({tag, "_errors"},      err_v[v.idx], v.e_err);
        chk({tag, "_first_error"}, ferr_v[v.idx], v.e_first);
        chk({tag, "_last_value"},  last_v[v.idx], v.e_last);
        chk({tag, "_rx_time"},     rx_v[v.idx], v.e_rx);
        chk({tag, "_max_gap"},     gap_v[v.idx], v.e_gap);
        @(negedge clock);
        chk({tag, "_state_done"},  st_v[v.idx], DONE);
        chk({tag, "_beats_hold"},  beats_v[v.idx], v.e_beats);
    endtask

    initial begin
        logic exp_tr;
        //           idx n  stamps                                up     last   mask   sl  beats err first last rx  gap
        vecs[0] = mk(3, 4, 10, 11, 12, 13, 0, 0, 0, 0,            8'h00, 8'h0F, 8'h00, 1, 4, 0, 0, 13,  3, 1);
        vecs[1] = mk(4, 5, 100, 101, 101, 99, 102, 0, 0, 0,       8'h00, 8'h1F, 8'h00, 0, 5, 2, 3, 102, 4, 1);
        vecs[2] = mk(2, 3, 1, 2, 3, 0, 0, 0, 0, 0,                8'h02, 8'h03, 8'h00, 0, 3, 2, 2, 3,   2, 1);
        vecs[3] = mk(5, 8, 1, 2, 3, 4, 5, 6, 7, 8,                8'h00, 8'hFF, 8'hAA, 0, 8, 0, 0, 8,  14, 2);
        vecs[4] = mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0,                8'h00, 8'h01, 8'h00, 0, 1, 0, 0, 5,   0, 0);

        // Reset values while reset is held.
        @(negedge clock);
        @(negedge clock);
        chk("rst_tready",   tready_v[0], 0);
        chk("rst_busy",     busy_v[0], 0);
        chk("rst_done",     done_v[0], 0);
        chk("rst_beats",    beats_v[5], 0);
        chk("rst_errors",   err_v[5], 0);
        chk("rst_last",     last_v[5], 0);
        chk("rst_state",    st_v[5], IDLE);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_tready",  tready_v[0], 1);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // TREADY follows ~stall_mask[cyc-1] while armed.
        do_reset();
        stall_mask = 8'hAA;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            exp_tr = ~stall_mask[3'(tb_cyc - 64'd1)];
            chk("stall_tready", tready_v[5], exp_tr);
            @(negedge clock);
        end

        // IDLE beats are discarded; DONE beats too; restart clears results.
        do_reset();
        tlast = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tdata = 256'(50 + k);
            offer(1);
        end
        tvalid = 1'b0;
        chk("idle_beats",   beats_v[1], 0);
        chk("idle_busy",    busy_v[1], 0);
        chk("idle_last",    last_v[1], 0);
        pulse_start();
        chk("arm_busy",     busy_v[1], 1);
        tdata = 256'd7; offer(1);
        tdata = 256'd7; offer(1);
        tvalid = 1'b0;
        chk("bc2_beats",    beats_v[1], 2);
        chk("bc2_errors",   err_v[1], 1);
        chk("bc2_first",    ferr_v[1], 2);
        chk("bc2_done",     done_v[1], 1);
        tdata = 256'd9; offer(1);
        tvalid = 1'b0;
        chk("done_drain_beats", beats_v[1], 2);
        chk("done_drain_last",  last_v[1], 7);
        pulse_start();
        chk("rearm_done",   done_v[1], 0);
        chk("rearm_busy",   busy_v[1], 1);
        chk("rearm_beats",  beats_v[1], 0);
        chk("rearm_errors", err_v[1], 0);
        chk("rearm_first",  ferr_v[1], 0);
        chk("rearm_gap",    gap_v[1], 0);

        // Reset in the middle of a window.
        do_reset();
        pulse_start();
        tlast = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tdata = 256'(20 + k);
            offer(5);
        end
        tvalid = 1'b0;
        chk("mid_beats",    beats_v[5], 3);
        chk("mid_gap",      gap_v[5], 1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_tready", tready_v[5], 0);
        chk("mid_rst_busy",   busy_v[5], 0);
        chk("mid_rst_done",   done_v[5], 0);
        chk("mid_rst_beats",  beats_v[5], 0);
        chk("mid_rst_last",   last_v[5], 0);
        chk("mid_rst_gap",    gap_v[5], 0);
        chk("mid_rst_state",  st_v[5], IDLE);
        reset = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
